// File: rtl/mcu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mcu_pkg
// Description : Shared types and constants for the multicycle MIPS control
//               unit: FSM state enum, opcode/funct values, ALU operation
//               encodings and datapath mux select codes.
// Revision    : 1.0 - initial release
// ============================================================================
package mcu_pkg;

    // Controller states; S_JUMP is only reachable when MCU_JUMP_EN is defined
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_ADDIEXE = 4'd8,
        S_ADDIWB  = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    // R-type function codes
    localparam logic [5:0] FUNCT_ADD = 6'h20;
    localparam logic [5:0] FUNCT_SUB = 6'h22;
    localparam logic [5:0] FUNCT_AND = 6'h24;
    localparam logic [5:0] FUNCT_OR  = 6'h25;
    localparam logic [5:0] FUNCT_SLT = 6'h2A;

    // ALU operation encodings (zero-extended to the ALUControl width)
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    // ALU B operand select
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage : mcu_pkg
`default_nettype wire

// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit_if
// Description : Bundle between the control unit and the multicycle datapath.
//               master = control unit, slave = datapath.
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int ICNT_WIDTH     = 32
);
    // Instruction fields and ALU status from the datapath
    logic [5:0]                OP;
    logic [5:0]                Funct;
    logic                      Zero;

    // Datapath control lines
    logic                      PCWrite;
    logic                      IorD;
    logic                      MemWrite;
    logic                      IRWrite;
    logic                      RegDst;
    logic                      MemtoReg;
    logic                      RegWrite;
    logic                      ALUSrcA;
    logic [1:0]                ALUSrcB;
    logic [ALU_CTRL_WIDTH-1:0] ALUControl;
    logic [1:0]                PCSrc;

    // Status
    logic                      instr_done_o;
    logic                      illegal_op_o;
    logic [ICNT_WIDTH-1:0]     instr_cnt_o;

    modport master (
        input  OP, Funct, Zero,
        output PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc,
               instr_done_o, illegal_op_o, instr_cnt_o
    );

    modport slave (
        output OP, Funct, Zero,
        input  PCWrite, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
               ALUSrcA, ALUSrcB, ALUControl, PCSrc,
               instr_done_o, illegal_op_o, instr_cnt_o
    );
endinterface : multicycle_control_unit_if
`default_nettype wire

// File: rtl/multicycle_control_unit_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Combinational R-type Funct -> ALU operation decode with a
//               validity flag for unsupported function codes.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mcu_pkg::*;
(
    input  wire logic [5:0] i_funct,
    output logic      [3:0] o_alu_ctrl,
    output logic            o_funct_valid
);

    // Map the supported function codes; anything else is flagged invalid
    always_comb begin
        o_alu_ctrl    = ALU_ADD;
        o_funct_valid = 1'b1;
        case (i_funct)
            FUNCT_ADD: o_alu_ctrl = ALU_ADD;
            FUNCT_SUB: o_alu_ctrl = ALU_SUB;
            FUNCT_AND: o_alu_ctrl = ALU_AND;
            FUNCT_OR:  o_alu_ctrl = ALU_OR;
            FUNCT_SLT: o_alu_ctrl = ALU_SLT;
            default:   o_funct_valid = 1'b0;
        endcase
    end

endmodule : alu_decoder
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control_unit
// Description : Moore control FSM for the multicycle MIPS datapath. Sequences
//               fetch/decode/execute/memory/writeback, drives every datapath
//               control line per state and counts retired instructions.
//               Optional feature macro: MCU_JUMP_EN (enables the j / JUMP
//               state; otherwise opcode 0x02 is illegal and PCSrc[1] is 0).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALU_CTRL_WIDTH = 4,
    parameter int ICNT_WIDTH     = 32
) (
    input  wire logic                  clk,
    input  wire logic                  reset,   // asynchronous, active-low
    multicycle_control_unit_if.master  bus
);

    state_t                r_state;
    logic                  r_is_sw;       // lw/sw remembered from DECODE
    logic [3:0]            r_alu_ctrl;    // R-type ALU op captured in DECODE
    logic [ICNT_WIDTH-1:0] r_instr_cnt;

    logic [3:0]            w_dec_alu;
    logic                  w_funct_valid;
    logic                  w_op_legal;

    logic                  w_pcwrite;
    logic                  w_iord;
    logic                  w_memwrite;
    logic                  w_irwrite;
    logic                  w_regdst;
    logic                  w_memtoreg;
    logic                  w_regwrite;
    logic                  w_srca;
    logic [1:0]            w_srcb;
    logic [3:0]            w_alu;
    logic [1:0]            w_pcsrc;
    logic                  w_done;
    logic                  w_illegal;

    // Single Funct decoder: checked in DECODE, its result held for EXECUTE
    alu_decoder u_alu_decoder (
        .i_funct       (bus.Funct),
        .o_alu_ctrl    (w_dec_alu),
        .o_funct_valid (w_funct_valid)
    );

    // Whether the opcode/funct pair seen in DECODE is supported
    always_comb begin
        w_op_legal = 1'b0;
        case (bus.OP)
            OP_LW, OP_SW, OP_ADDI, OP_BEQ: w_op_legal = 1'b1;
            OP_RTYPE:                      w_op_legal = w_funct_valid;
`ifdef MCU_JUMP_EN
            OP_J:                          w_op_legal = 1'b1;
`else
            OP_J:                          w_op_legal = 1'b0;
`endif
            default:                       w_op_legal = 1'b0;
        endcase
    end

    // State sequencing plus retired-instruction counting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_FETCH;
            r_is_sw     <= 1'b0;
            r_alu_ctrl  <= ALU_ADD;
            r_instr_cnt <= '0;
        end else begin
            r_instr_cnt <= r_instr_cnt + ICNT_WIDTH'(w_done);
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    r_state <= S_FETCH;
                    case (bus.OP)
                        OP_LW: begin
                            r_state <= S_MEMADR;
                            r_is_sw <= 1'b0;
                        end
                        OP_SW: begin
                            r_state <= S_MEMADR;
                            r_is_sw <= 1'b1;
                        end
                        OP_RTYPE: begin
                            if (w_funct_valid) begin
                                r_state    <= S_EXECUTE;
                                r_alu_ctrl <= w_dec_alu;
                            end
                        end
                        OP_ADDI: r_state <= S_ADDIEXE;
                        OP_BEQ:  r_state <= S_BRANCH;
`ifdef MCU_JUMP_EN
                        OP_J:    r_state <= S_JUMP;
`else
                        OP_J:    r_state <= S_FETCH;
`endif
                        default: r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= r_is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:   r_state <= S_MEMWB;
                S_EXECUTE: r_state <= S_ALUWB;
                S_ADDIEXE: r_state <= S_ADDIWB;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    // Per-state control decode from the registered state (Zero only in BRANCH)
    always_comb begin
        w_pcwrite  = 1'b0;
        w_iord     = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regdst   = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_srca     = 1'b0;
        w_srcb     = SRCB_REG;
        w_alu      = ALU_ADD;
        w_pcsrc    = PCSRC_ALU;
        w_done     = 1'b0;
        w_illegal  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_srcb    = SRCB_FOUR;
                w_pcwrite = 1'b1;
            end
            S_DECODE: begin
                w_srcb    = SRCB_IMM_SH2;
                w_illegal = ~w_op_legal;
            end
            S_MEMADR: begin
                w_srca = 1'b1;
                w_srcb = SRCB_IMM;
            end
            S_MEMRD: w_iord = 1'b1;
            S_MEMWB: begin
                w_memtoreg = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_EXECUTE: begin
                w_srca = 1'b1;
                w_alu  = r_alu_ctrl;
            end
            S_ALUWB: begin
                w_regdst   = 1'b1;
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_ADDIEXE: begin
                w_srca = 1'b1;
                w_srcb = SRCB_IMM;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_BRANCH: begin
                w_srca    = 1'b1;
                w_alu     = ALU_SUB;
                w_pcsrc   = PCSRC_ALUOUT;
                w_pcwrite = bus.Zero;
                w_done    = 1'b1;
            end
`ifdef MCU_JUMP_EN
            S_JUMP: begin
                w_pcsrc   = PCSRC_JUMP;
                w_pcwrite = 1'b1;
                w_done    = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // Every output is held at zero for as long as reset is low
    assign bus.PCWrite      = reset & w_pcwrite;
    assign bus.IorD         = reset & w_iord;
    assign bus.MemWrite     = reset & w_memwrite;
    assign bus.IRWrite      = reset & w_irwrite;
    assign bus.RegDst       = reset & w_regdst;
    assign bus.MemtoReg     = reset & w_memtoreg;
    assign bus.RegWrite     = reset & w_regwrite;
    assign bus.ALUSrcA      = reset & w_srca;
    assign bus.ALUSrcB      = reset ? w_srcb : 2'b00;
    assign bus.ALUControl   = reset ? ALU_CTRL_WIDTH'(w_alu) : '0;
`ifdef MCU_JUMP_EN
    assign bus.PCSrc        = reset ? w_pcsrc : 2'b00;
`else
    // Without the jump path the upper PCSrc bit can never be set
    assign bus.PCSrc        = reset ? (w_pcsrc & ~PCSRC_JUMP) : 2'b00;
`endif
    assign bus.instr_done_o = reset & w_done;
    assign bus.illegal_op_o = reset & w_illegal;
    assign bus.instr_cnt_o  = r_instr_cnt;

endmodule : multicycle_control_unit
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control_unit
// Description : Self-checking bench for multicycle_control_unit. Each
//               instruction's expected per-cycle control vector is built from
//               the instruction class and cycle index.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_ADDI = 3, K_BEQ = 4,
                   K_J = 5, K_ILL = 6;

    logic        clk = 1'b0;
    logic        reset;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_cnt  = 32'd0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_CTRL_WIDTH(4), .ICNT_WIDTH(32)) bus ();

    multicycle_control_unit #(.ALU_CTRL_WIDTH(4), .ICNT_WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {PCWrite,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
    //  ALUSrcB[1:0],ALUControl[3:0],PCSrc[1:0],instr_done,illegal_op}
    function automatic logic [17:0] dut_vec();
        return {bus.PCWrite, bus.IorD, bus.MemWrite, bus.IRWrite, bus.RegDst,
                bus.MemtoReg, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                bus.ALUControl, bus.PCSrc, bus.instr_done_o, bus.illegal_op_o};
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b0100;
            6'h22:   return 4'b0101;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic bit funct_ok(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) ||
               (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic int kind_of(input logic [5:0] op, input logic [5:0] f);
        case (op)
            6'h23:   return K_LW;
            6'h2B:   return K_SW;
            6'h00:   return funct_ok(f) ? K_R : K_ILL;
            6'h08:   return K_ADDI;
            6'h04:   return K_BEQ;
`ifdef MCU_JUMP_EN
            6'h02:   return K_J;
`endif
            default: return K_ILL;
        endcase
    endfunction

    function automatic int cycles_of(input int k);
        case (k)
            K_LW:    return 5;
            K_SW, K_R, K_ADDI: return 4;
            K_BEQ, K_J: return 3;
            default: return 2;
        endcase
    endfunction

    // Expected control vector for cycle 'step' of an instruction of class k
    function automatic logic [17:0] expect_vec(input int k, input int step,
                                               input logic [5:0] f, input logic zero);
        logic pcw, iord, mw, irw, rdst, m2r, rw, sa, done, ill;
        logic [1:0] sb, pcs;
        logic [3:0] alu;
        {pcw, iord, mw, irw, rdst, m2r, rw, sa, done, ill} = '0;
        sb = 2'b00; pcs = 2'b00; alu = 4'b0100;
        if (step == 0) begin
            irw = 1'b1; pcw = 1'b1; sb = 2'b01;
        end else if (step == 1) begin
            sb = 2'b11; ill = (k == K_ILL);
        end else begin
            case (k)
                K_LW: begin
                    if (step == 2) begin sa = 1'b1; sb = 2'b10; end
                    else if (step == 3) iord = 1'b1;
                    else begin m2r = 1'b1; rw = 1'b1; done = 1'b1; end
                end
                K_SW: begin
                    if (step == 2) begin sa = 1'b1; sb = 2'b10; end
                    else begin iord = 1'b1; mw = 1'b1; done = 1'b1; end
                end
                K_R: begin
                    if (step == 2) begin sa = 1'b1; alu = alu_of(f); end
                    else begin rdst = 1'b1; rw = 1'b1; done = 1'b1; end
                end
                K_ADDI: begin
                    if (step == 2) begin sa = 1'b1; sb = 2'b10; end
                    else begin rw = 1'b1; done = 1'b1; end
                end
                K_BEQ: begin
                    sa = 1'b1; alu = 4'b0101; pcs = 2'b01; pcw = zero; done = 1'b1;
                end
                K_J: begin
                    pcs = 2'b10; pcw = 1'b1; done = 1'b1;
                end
                default: ;
            endcase
        end
        return {pcw, iord, mw, irw, rdst, m2r, rw, sa, sb, alu, pcs, done, ill};
    endfunction

    // Runs one instruction starting just after the edge that entered FETCH.
    // OP/Funct carry the real values only in DECODE; random noise elsewhere.
    // zero_mode < 0 gives a random Zero. abort_step >= 0 drops reset mid-way.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] f,
                             input string name, input int zero_mode,
                             input int abort_step);
        int k = kind_of(op, f);
        int n = cycles_of(k);
        logic [17:0] exp_v;
        for (int step = 0; step < n; step++) begin
            bus.OP    = (step == 1) ? op : 6'($urandom);
            bus.Funct = (step == 1) ? f  : 6'($urandom);
            bus.Zero  = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
            #4;
            exp_v = expect_vec(k, step, f, bus.Zero);
            checks++;
            if (dut_vec() !== exp_v) begin
                failures++;
                $display("FAIL %s step%0d ctrl: got %b expected %b", name, step, dut_vec(), exp_v);
            end
            checks++;
            if (bus.instr_cnt_o !== exp_cnt) begin
                failures++;
                $display("FAIL %s step%0d count: got %0d expected %0d", name, step, bus.instr_cnt_o, exp_cnt);
            end
            if (step == abort_step) begin
                #2 reset = 1'b0;
                #1;
                exp_cnt = 32'd0;
                checks++;
                if (dut_vec() !== 18'd0 || bus.instr_cnt_o !== 32'd0) begin
                    failures++;
                    $display("FAIL %s abort: got ctrl %b cnt %0d expected all zero", name, dut_vec(), bus.instr_cnt_o);
                end
                @(posedge clk); #1;
                checks++;
                if (dut_vec() !== 18'd0) begin
                    failures++;
                    $display("FAIL %s held_reset: got %b expected 0", name, dut_vec());
                end
                reset = 1'b1;
                return;
            end
            if (step == n - 1 && k != K_ILL) exp_cnt = exp_cnt + 32'd1;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.OP = 6'h23; bus.Funct = 6'h20; bus.Zero = 1'b1;
        exp_cnt = 32'd0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (dut_vec() !== 18'd0 || bus.instr_cnt_o !== 32'd0) begin
                failures++;
                $display("FAIL reset_cycle%0d: got ctrl %b cnt %0d expected zero", c, dut_vec(), bus.instr_cnt_o);
            end
        end
        reset = 1'b1;
        #1;
        checks++;
        if (dut_vec() !== expect_vec(K_LW, 0, 6'h20, 1'b0)) begin
            failures++;
            $display("FAIL reset_first_fetch: got %b expected %b", dut_vec(), expect_vec(K_LW, 0, 6'h20, 1'b0));
        end
    endtask

    task automatic test_lw();       run_instr(6'h23, 6'($urandom), "lw", -1, -1); endtask
    task automatic test_sw();       run_instr(6'h2B, 6'($urandom), "sw", -1, -1); endtask
    task automatic test_addi();     run_instr(6'h08, 6'($urandom), "addi", -1, -1); endtask

    task automatic test_rtype();
        logic [5:0] fl [5] = '{6'h22, 6'h2A, 6'h20, 6'h24, 6'h25};
        foreach (fl[i]) run_instr(6'h00, fl[i], "rtype", -1, -1);
    endtask

    task automatic test_beq();
        run_instr(6'h04, 6'h00, "beq_taken", 1, -1);
        run_instr(6'h04, 6'h00, "beq_not_taken", 0, -1);
    endtask

    task automatic test_illegal();
        run_instr(6'h3F, 6'h20, "illegal_3f", -1, -1);
        run_instr(6'h02, 6'h20, "op_02", -1, -1);
        run_instr(6'h00, 6'h21, "illegal_funct", -1, -1);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [7] = '{6'h23, 6'h2B, 6'h00, 6'h08, 6'h04, 6'h02, 6'h3F};
        logic [5:0] fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        logic [5:0] op, f;
        for (int i = 0; i < 60; i++) begin
            op = ops[$urandom_range(6)];
            if (op == 6'h3F) op = 6'($urandom);
            f  = ($urandom_range(3) == 0) ? 6'($urandom) : fns[$urandom_range(4)];
            run_instr(op, f, "b2b", -1, -1);
        end
    endtask

    task automatic test_midop_reset();
        run_instr(6'h23, 6'h00, "midop_lw", -1, 3);
        run_instr(6'h00, 6'h2A, "after_reset", -1, -1);
    endtask

    initial begin
        bus.OP = 6'h00; bus.Funct = 6'h00; bus.Zero = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_rtype();
        test_addi();
        test_beq();
        test_illegal();
        test_back_to_back();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_multicycle_control_unit
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Moore-style control FSM for the multicycle MIPS datapath. It replaces the hand-driven control signals used in datapath benches today. It decodes OP/Funct from the instruction register and sequences fetch, decode, execute, memory and writeback. Every datapath control line is driven per state, and the block counts retired instructions.

## Interface
Parameters:
- ALU_CTRL_WIDTH, 4, width of ALUControl
- ICNT_WIDTH, 32, width of retired-instruction counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- OP  in  6  instruction opcode from IR
- Funct  in  6  R-type function field from IR
- Zero  in  1  ALU zero flag
- PCWrite  out  1  effective PC enable (unconditional write OR branch-taken)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback data: 0 = ALUOut, 1 = memory data
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = register A
- ALUSrcB  out  2  ALU B: 00 = register B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
- ALUControl  out  ALU_CTRL_WIDTH  ALU operation
- PCSrc  out  2  PC source: 00 = ALUResult, 01 = ALUOut, 10 = jump target
- instr_done_o  out  1  one-cycle pulse in the final state of each instruction
- illegal_op_o  out  1  one-cycle pulse when DECODE sees an unsupported OP/Funct
- instr_cnt_o  out  ICNT_WIDTH  retired-instruction count

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, ADDIEXE, ADDIWB, BRANCH, JUMP.
- FETCH
  - Asserts IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00, PCWrite=1.
  - Always goes to DECODE.
- DECODE
  - Asserts ALUSrcA=0, ALUSrcB=11, ALUControl=ADD; this precomputes the branch target.
  - Next state by OP:
    - 0x23 (lw) or 0x2B (sw) -> MEMADR
    - 0x00 (R-type) -> EXECUTE
    - 0x08 (addi) -> ADDIEXE
    - 0x04 (beq) -> BRANCH
    - 0x02 (j) -> JUMP
    - any other OP -> FETCH, with illegal_op_o pulsed
- MEMADR
  - Asserts ALUSrcA=1, ALUSrcB=10, ADD.
  - lw -> MEMRD; sw -> MEMWR.
- MEMRD: IorD=1 -> MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWR: IorD=1, MemWrite=1 -> FETCH.
- EXECUTE
  - Asserts ALUSrcA=1, ALUSrcB=00, ALUControl decoded from Funct.
  - Funct mapping: 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x2A SLT.
  - Unsupported Funct is caught in DECODE: go to FETCH and pulse illegal_op_o.
  - EXECUTE -> ALUWB.
- ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 -> FETCH.
- ADDIEXE: ALUSrcA=1, ALUSrcB=10, ADD -> ADDIWB.
- ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 -> FETCH.
- BRANCH
  - Asserts ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=01.
  - PCWrite = Zero (combinational from Zero).
  - -> FETCH.
- JUMP: PCSrc=10, PCWrite=1 -> FETCH.
- Outputs not listed for a state are 0 (ALUControl = ADD).
- instr_done_o is high in MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
- instr_cnt_o increments when instr_done_o is high, wraps modulo 2^ICNT_WIDTH, and is not incremented on illegal ops.
- ALU encodings, zero-extended into ALU_CTRL_WIDTH: AND=0000, OR=0001, ADD=0100, SUB=0101, SLT=0111. ALU_CTRL_WIDTH < 4 is illegal.

## Timing
- Reset asserted, at any time including mid-instruction:
  - state = FETCH immediately (asynchronous).
  - instr_cnt_o = 0, illegal_op_o = 0, instr_done_o = 0.
  - Every control output is forced to 0, including PCWrite and IRWrite, and stays 0 while reset is low.
- First FETCH outputs appear in the first cycle after reset deasserts.
- Outputs decode from the registered state only; the single exception is PCWrite in BRANCH, which follows Zero in the same cycle.
- OP/Funct are sampled in DECODE only; later changes on those inputs are ignored.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.
- illegal_op_o is high during the DECODE cycle; the next state is FETCH.
- instr_cnt_o updates on the clock edge that leaves the final state.

## Configuration
- MCU_JUMP_EN defined: OP 0x02 goes to the JUMP state.
- MCU_JUMP_EN undefined:
  - The JUMP state is not built.
  - OP 0x02 is treated as illegal: go to FETCH and pulse illegal_op_o.
  - PCSrc[1] is tied 0.

## Structure
- Package mcu_pkg holds:
  - the state enum
  - OP constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J
  - Funct constants
  - ALU encodings: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT
  - ALUSrcB and PCSrc select constants
- Sub-module alu_decoder: combinational Funct -> ALUControl plus a funct_valid output. It is instantiated once and used in both DECODE and EXECUTE.

## Test plan
- Reset:
  - Hold reset=0 for 3 cycles, then release.
  - Expect all outputs 0 during reset.
  - Next cycle: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUControl=0100.
- lw:
  - OP=0x23.
  - Expect state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB.
  - In MEMWB: MemtoReg=1, RegWrite=1, RegDst=0.
  - instr_cnt_o goes 0 -> 1 after 5 cycles.
- R-type:
  - OP=0x00, Funct=0x22.
  - EXECUTE: ALUControl=0101, ALUSrcA=1, ALUSrcB=00.
  - ALUWB: RegDst=1, RegWrite=1.
  - Funct=0x2A gives ALUControl=0111.
- beq:
  - OP=0x04 with Zero=1 in BRANCH: PCWrite=1, PCSrc=01.
  - Repeat with Zero=0: PCWrite=0.
  - Both runs take 3 cycles.
- Illegal op:
  - OP=0x3F gives illegal_op_o=1 in the DECODE cycle, then FETCH, with instr_cnt_o unchanged.
  - Repeat with OP=0x02 and MCU_JUMP_EN undefined: same result.
  - With MCU_JUMP_EN defined, OP=0x02 reaches JUMP with PCSrc=10, PCWrite=1.
- Mid-op reset:
  - Drop reset in MEMRD of an lw.
  - Expect outputs 0 immediately; after release, FETCH with instr_cnt_o=0.
